instr_encoder_loader: RTL and testbench

Streams compact instruction descriptors into instruction memory as encoded RV32I words, the encoding counterpart of the core's opcode/ALU decode. It sits beside the single-cycle core on the instruction-memory write port and is used to build self-test programs and for bench-driven program loading. Each accepted descriptor is range-checked, encoded with the shared opcode and ALU-op types, and written to consecutive word addresses starting at a base address.

---
 rtl/instr_encoder_loader_pkg.sv | 55 +++++
 rtl/instr_encoder_loader_if.sv | 28 ++
 rtl/instr_encoder_loader_encoder.sv | 60 ++++++
 rtl/instr_encoder_loader.sv | 130 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// rtl/instr_encoder_loader_pkg.sv - shared RV32I opcode, ALU-op and loader descriptor types
`timescale 1ns/1ps
package instr_encoder_loader_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111
  } ty_OPERAND;

  // bit 3 selects the alternate funct7 encoding, bits 2:0 are funct3
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b1000,
    ALU_AND = 4'b0111,
    ALU_OR  = 4'b0110,
    ALU_XOR = 4'b0100
  } ty_ALU_OP;

  typedef enum logic [2:0] {
    CMD_LW    = 3'd0,
    CMD_SW    = 3'd1,
    CMD_R_ALU = 3'd2,
    CMD_I_ALU = 3'd3,
    CMD_BEQ   = 3'd4,
    CMD_JAL   = 3'd5
  } ty_CMD_KIND;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RANGE    = 2'd1,
    ERR_ILLEGAL  = 2'd2,
    ERR_OVERFLOW = 2'd3
  } ty_ENC_ERR;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_ERROR
  } ty_LDR_STATE;

  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  function automatic logic alu_op_defined(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
           (op == ALU_OR)  || (op == ALU_XOR);
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - descriptor stream and instruction-memory write port bundle
`timescale 1ns/1ps
interface instr_encoder_loader_if;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [2:0]  i_cmd_kind;
  logic [3:0]  i_cmd_aluop;
  logic [4:0]  i_cmd_rd;
  logic [4:0]  i_cmd_rs1;
  logic [4:0]  i_cmd_rs2;
  logic [20:0] i_cmd_imm;
  logic        i_cmd_last;
  logic        o_imem_we;
  logic [31:0] o_imem_addr;
  logic [31:0] o_imem_wdata;

  modport master (
    output i_cmd_valid, i_cmd_kind, i_cmd_aluop, i_cmd_rd, i_cmd_rs1, i_cmd_rs2,
           i_cmd_imm, i_cmd_last,
    input  o_cmd_ready, o_imem_we, o_imem_addr, o_imem_wdata
  );

  modport slave (
    input  i_cmd_valid, i_cmd_kind, i_cmd_aluop, i_cmd_rd, i_cmd_rs1, i_cmd_rs2,
           i_cmd_imm, i_cmd_last,
    output o_cmd_ready, o_imem_we, o_imem_addr, o_imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader_encoder.sv
// rtl/instr_encoder_loader_encoder.sv - combinational descriptor-to-RV32I encoder (INSTR_ENC_RANGE_CHECK_EN enables checks)
`timescale 1ns/1ps
module instr_word_encoder
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  i_kind,
  input  logic [3:0]  i_aluop,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [20:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_range_err,
  output logic        o_illegal
);

  always_comb begin
    o_word = '0;
    case (i_kind)
      CMD_LW:    o_word = {i_imm[11:0], i_rs1, F3_LW, i_rd, OP_LOAD};
      CMD_SW:    o_word = {i_imm[11:5], i_rs2, i_rs1, F3_SW, i_imm[4:0], OP_STORE};
      CMD_R_ALU: o_word = {1'b0, i_aluop[3], 5'b0, i_rs2, i_rs1, i_aluop[2:0], i_rd, OP_REG};
      CMD_I_ALU: o_word = {i_imm[11:0], i_rs1, i_aluop[2:0], i_rd, OP_IMM};
      CMD_BEQ:   o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BEQ,
                           i_imm[4:1], i_imm[11], OP_BRANCH};
      CMD_JAL:   o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
      default:   o_word = '0;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  logic fits12;
  logic fits13;

  always_comb begin
    fits12      = (i_imm[20:11] == {10{i_imm[11]}});
    fits13      = (i_imm[20:12] == {9{i_imm[12]}});
    o_range_err = 1'b0;
    o_illegal   = 1'b0;
    case (i_kind)
      CMD_LW, CMD_SW: o_range_err = !fits12;
      CMD_R_ALU:      o_illegal   = !alu_op_defined(i_aluop);
      CMD_I_ALU: begin
        o_range_err = !fits12;
        o_illegal   = (i_aluop == ALU_SUB) || !alu_op_defined(i_aluop);
      end
      CMD_BEQ:        o_range_err = !fits13 || i_imm[0];
      CMD_JAL:        o_range_err = i_imm[0];
      default:        o_illegal   = 1'b1;
    endcase
  end
`else
  // without checking, bit 0 of the byte offset is simply dropped
  logic unused_imm0;
  assign unused_imm0 = i_imm[0];
  assign o_range_err = 1'b0;
  assign o_illegal   = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - loads encoded RV32I words into instruction memory (INSTR_ENC_RANGE_CHECK_EN)
`timescale 1ns/1ps
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  instr_encoder_loader_if.slave bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [1:0]            o_err_code
);

  localparam int IDX_W = $clog2(IMEM_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMEM_DEPTH - 1);

  ty_LDR_STATE      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  ty_ENC_ERR        err_code_q, err_code_d;

  logic [31:0]      enc_word;
  logic             enc_range;
  logic             enc_illegal;
  ty_ENC_ERR        enc_err;

  instr_word_encoder u_enc (
    .i_kind      (bus.i_cmd_kind),
    .i_aluop     (bus.i_cmd_aluop),
    .i_rd        (bus.i_cmd_rd),
    .i_rs1       (bus.i_cmd_rs1),
    .i_rs2       (bus.i_cmd_rs2),
    .i_imm       (bus.i_cmd_imm),
    .o_word      (enc_word),
    .o_range_err (enc_range),
    .o_illegal   (enc_illegal)
  );

  assign enc_err = enc_illegal ? ERR_ILLEGAL : (enc_range ? ERR_RANGE : ERR_NONE);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    if (i_start) begin
      state_d    = ST_LOAD;
      idx_d      = '0;
      done_d     = 1'b0;
      error_d    = 1'b0;
      err_code_d = ERR_NONE;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (bus.i_cmd_valid) begin
            if (enc_err != ERR_NONE) begin
              state_d    = ST_ERROR;
              error_d    = 1'b1;
              err_code_d = enc_err;
            end else begin
              we_d    = 1'b1;
              addr_d  = BASE_ADDR + {{(30-IDX_W){1'b0}}, idx_q, 2'b00};
              wdata_d = enc_word;
              idx_d   = idx_q + IDX_W'(1);
              if (bus.i_cmd_last) begin
                state_d = ST_DONE;
              end else if (idx_q == LAST_IDX) begin
                state_d = ST_ERROR;
              end
            end
          end
        end
        // status flags trail the final write by one cycle
        ST_DONE: done_d = 1'b1;
        ST_ERROR: begin
          if (!error_q) begin
            error_d    = 1'b1;
            err_code_d = ERR_OVERFLOW;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.o_cmd_ready  = (state_q == ST_LOAD);
  assign bus.o_imem_we    = we_q;
  assign bus.o_imem_addr  = addr_q;
  assign bus.o_imem_wdata = wdata_q;
  assign o_busy           = (state_q == ST_LOAD);
  assign o_done           = done_q;
  assign o_error          = error_q;
  assign o_err_code       = err_code_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - scoreboard bench for instr_encoder_loader
`timescale 1ns/1ps
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, error;
  logic [1:0] err_code;
  int         checks = 0;
  int         errors = 0;
  wr_t        exp_q[$];
  wr_t        mon_e;

  instr_encoder_loader_if bus();

  instr_encoder_loader #(.IMEM_DEPTH(4), .BASE_ADDR(32'h0)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .bus        (bus),
    .o_busy     (busy),
    .o_done     (done),
    .o_error    (error),
    .o_err_code (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                 bus.o_imem_addr, bus.o_imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", bus.o_imem_addr, mon_e.addr);
        chk("write_data", bus.o_imem_wdata, mon_e.data);
      end
    end
  end

  task automatic send(input logic [2:0] kind, input logic [3:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [20:0] imm,
                      input logic last, input bit wr, input logic [31:0] ea,
                      input logic [31:0] ed);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_kind  = kind;
    bus.i_cmd_aluop = op;
    bus.i_cmd_rd    = rd;
    bus.i_cmd_rs1   = rs1;
    bus.i_cmd_rs2   = rs2;
    bus.i_cmd_imm   = imm;
    bus.i_cmd_last  = last;
    if (wr) exp_q.push_back({ea, ed});
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic status(input string tag, input logic b, input logic r, input logic d,
                        input logic e, input logic [1:0] c);
    chk({tag, "_busy"}, {31'b0, busy}, {31'b0, b});
    chk({tag, "_ready"}, {31'b0, bus.o_cmd_ready}, {31'b0, r});
    chk({tag, "_done"}, {31'b0, done}, {31'b0, d});
    chk({tag, "_error"}, {31'b0, error}, {31'b0, e});
    chk({tag, "_code"}, {30'b0, err_code}, {30'b0, c});
  endtask

  initial begin
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_kind  = '0;
    bus.i_cmd_aluop = '0;
    bus.i_cmd_rd    = '0;
    bus.i_cmd_rs1   = '0;
    bus.i_cmd_rs2   = '0;
    bus.i_cmd_imm   = '0;
    bus.i_cmd_last  = 1'b0;

    #12;
    status("reset", 1'b0, 1'b0, 1'b0, 1'b0, ERR_NONE);
    chk("reset_we", {31'b0, bus.o_imem_we}, 32'h0);
    chk("reset_addr", bus.o_imem_addr, 32'h0);
    chk("reset_wdata", bus.o_imem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    status("idle", 1'b0, 1'b0, 1'b0, 1'b0, ERR_NONE);

    // ADD/SUB back to back; descriptor in start cycle is ignored
    start = 1'b1;
    send(CMD_R_ALU, ALU_ADD, 5'd9, 5'd9, 5'd9, 21'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    start = 1'b0;
    status("s1_load", 1'b1, 1'b1, 1'b0, 1'b0, ERR_NONE);
    send(CMD_R_ALU, ALU_ADD, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0, 1'b1, 32'h0, 32'h002081B3);
    send(CMD_R_ALU, ALU_SUB, 5'd5, 5'd6, 5'd7, 21'd0, 1'b1, 1'b1, 32'h4, 32'h407302B3);
    status("s1_last", 1'b0, 1'b0, 1'b0, 1'b0, ERR_NONE);
    @(negedge clk);
    status("s1_done", 1'b0, 1'b0, 1'b1, 1'b0, ERR_NONE);
    send(CMD_R_ALU, ALU_ADD, 5'd1, 5'd1, 5'd1, 21'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    status("s1_hold", 1'b0, 1'b0, 1'b1, 1'b0, ERR_NONE);

    // LW / SW / JAL
    do_start();
    send(CMD_LW, ALU_ADD, 5'd2, 5'd0, 5'd0, 21'd8, 1'b0, 1'b1, 32'h0, 32'h00802103);
    send(CMD_SW, ALU_ADD, 5'd0, 5'd3, 5'd2, 21'd4, 1'b0, 1'b1, 32'h4, 32'h0021A223);
    send(CMD_JAL, ALU_ADD, 5'd1, 5'd0, 5'd0, 21'd8, 1'b1, 1'b1, 32'h8, 32'h008000EF);
    @(negedge clk);
    status("s2_done", 1'b0, 1'b0, 1'b1, 1'b0, ERR_NONE);

    // restart while in LOAD: the start-cycle descriptor is dropped, index resets
    do_start();
    start = 1'b1;
    send(CMD_LW, ALU_ADD, 5'd2, 5'd0, 5'd0, 21'd8, 1'b0, 1'b0, 32'h0, 32'h0);
    start = 1'b0;
    send(CMD_BEQ, ALU_ADD, 5'd0, 5'd1, 5'd2, 21'h1FFFFC, 1'b1, 1'b1, 32'h0, 32'hFE208EE3);
    @(negedge clk);
    status("s3_done", 1'b0, 1'b0, 1'b1, 1'b0, ERR_NONE);

    do_start();
`ifdef INSTR_ENC_RANGE_CHECK_EN
    send(CMD_I_ALU, ALU_ADD, 5'd1, 5'd0, 5'd0, 21'd3000, 1'b1, 1'b0, 32'h0, 32'h0);
    status("range", 1'b0, 1'b0, 1'b0, 1'b1, ERR_RANGE);
    do_start();
    status("range_restart", 1'b1, 1'b1, 1'b0, 1'b0, ERR_NONE);
    send(CMD_I_ALU, ALU_SUB, 5'd1, 5'd0, 5'd0, 21'd5, 1'b1, 1'b0, 32'h0, 32'h0);
    status("illegal", 1'b0, 1'b0, 1'b0, 1'b1, ERR_ILLEGAL);
`else
    send(CMD_I_ALU, ALU_ADD, 5'd1, 5'd0, 5'd0, 21'd3000, 1'b1, 1'b1, 32'h0, 32'hBB800093);
    status("trunc_last", 1'b0, 1'b0, 1'b0, 1'b0, ERR_NONE);
    @(negedge clk);
    status("trunc_done", 1'b0, 1'b0, 1'b1, 1'b0, ERR_NONE);
`endif

    // overflow: depth 4, no last
    do_start();
    send(CMD_R_ALU, ALU_XOR, 5'd4, 5'd5, 5'd6, 21'd0, 1'b0, 1'b1, 32'h0, 32'h0062C233);
    send(CMD_R_ALU, ALU_XOR, 5'd4, 5'd5, 5'd6, 21'd0, 1'b0, 1'b1, 32'h4, 32'h0062C233);
    send(CMD_R_ALU, ALU_XOR, 5'd4, 5'd5, 5'd6, 21'd0, 1'b0, 1'b1, 32'h8, 32'h0062C233);
    send(CMD_R_ALU, ALU_XOR, 5'd4, 5'd5, 5'd6, 21'd0, 1'b0, 1'b1, 32'hC, 32'h0062C233);
    status("ovf_write", 1'b0, 1'b0, 1'b0, 1'b0, ERR_NONE);
    send(CMD_R_ALU, ALU_XOR, 5'd4, 5'd5, 5'd6, 21'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    status("ovf_err", 1'b0, 1'b0, 1'b0, 1'b1, ERR_OVERFLOW);
    send(CMD_R_ALU, ALU_XOR, 5'd4, 5'd5, 5'd6, 21'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    status("ovf_hold", 1'b0, 1'b0, 1'b0, 1'b1, ERR_OVERFLOW);

    // last descriptor landing exactly on the final index completes normally
    do_start();
    send(CMD_R_ALU, ALU_AND, 5'd7, 5'd8, 5'd9, 21'd0, 1'b0, 1'b1, 32'h0, 32'h009473B3);
    send(CMD_R_ALU, ALU_AND, 5'd7, 5'd8, 5'd9, 21'd0, 1'b0, 1'b1, 32'h4, 32'h009473B3);
    send(CMD_R_ALU, ALU_AND, 5'd7, 5'd8, 5'd9, 21'd0, 1'b0, 1'b1, 32'h8, 32'h009473B3);
    send(CMD_R_ALU, ALU_AND, 5'd7, 5'd8, 5'd9, 21'd0, 1'b1, 1'b1, 32'hC, 32'h009473B3);
    @(negedge clk);
    status("edge_done", 1'b0, 1'b0, 1'b1, 1'b0, ERR_NONE);

    // asynchronous reset while a write strobe is high
    do_start();
    send(CMD_R_ALU, ALU_ADD, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0, 1'b1, 32'h0, 32'h002081B3);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_aluop = ALU_SUB;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    status("arst", 1'b0, 1'b0, 1'b0, 1'b0, ERR_NONE);
    chk("arst_we", {31'b0, bus.o_imem_we}, 32'h0);
    chk("arst_addr", bus.o_imem_addr, 32'h0);
    chk("arst_wdata", bus.o_imem_wdata, 32'h0);
    bus.i_cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    send(CMD_R_ALU, ALU_ADD, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 1'b1, 32'h0, 32'h002081B3);
    @(negedge clk);
    status("post_rst_done", 1'b0, 1'b0, 1'b1, 1'b0, ERR_NONE);

    @(negedge clk);
    chk("pending_writes", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
